// File: rtl/spin_update_pkg.sv
// Shared types and defaults for the sequential spin-sweep updater.
package spin_update_pkg;

  localparam int DATASPIN_DEF         = 256;
  localparam int LOCAL_ENERGY_BIT_DEF = 16;
  localparam int SWEEP_BIT_DEF        = 8;
  localparam int FLIP_CNT_BIT_DEF     = 16;

  // All-ones source for the flip counter; the top truncates it to its counter width.
  localparam logic [31:0] FLIP_CNT_SAT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/spin_sweep_updater_if.sv
// Energy-path bundle between the spin updater (master) and the partial energy calculator (slave).
// Handshake: energy_i is consumed on a rising clk edge where energy_valid_i && energy_ready_o;
// energy_ready_o depends on registered state only, and energy_i must describe spin_idx_o.
interface spin_sweep_updater_if #(
  parameter int DATASPIN         = 256,
  parameter int LOCAL_ENERGY_BIT = 16,
  parameter int IDX_BIT          = $clog2(DATASPIN)
);

  logic [DATASPIN-1:0]                spin_o;
  logic [IDX_BIT-1:0]                 spin_idx_o;
  logic                               current_spin_o;
  logic                               energy_valid_i;
  logic signed [LOCAL_ENERGY_BIT-1:0] energy_i;
  logic                               energy_ready_o;

  modport master (
    output spin_o,
    output spin_idx_o,
    output current_spin_o,
    output energy_ready_o,
    input  energy_valid_i,
    input  energy_i
  );

  modport slave (
    input  spin_o,
    input  spin_idx_o,
    input  current_spin_o,
    input  energy_ready_o,
    output energy_valid_i,
    output energy_i
  );

endinterface

// File: rtl/spin_flip_decide.sv
// Flip decision: a spin flips only when its local energy is strictly positive.
module spin_flip_decide #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] energy_i,
  output logic                flip_o
);

  localparam logic signed [W-1:0] ZERO = '0;

  assign flip_o = (energy_i > ZERO);

endmodule

// File: rtl/spin_sweep_updater.sv
// Gauss-Seidel spin updater: walks spins in order, flips on positive local energy,
// repeats for a programmable number of sweeps and stops early on a flip-free sweep.
module spin_sweep_updater
  import spin_update_pkg::*;
#(
  parameter int DATASPIN         = DATASPIN_DEF,
  parameter int LOCAL_ENERGY_BIT = LOCAL_ENERGY_BIT_DEF,
  parameter int SWEEP_BIT        = SWEEP_BIT_DEF,
  parameter int FLIP_CNT_BIT     = FLIP_CNT_BIT_DEF,
  parameter int IDX_BIT          = $clog2(DATASPIN)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    spin_load_valid_i,
  input  logic [DATASPIN-1:0]     spin_load_i,
  input  logic                    start_i,
  input  logic [SWEEP_BIT-1:0]    num_sweeps_i,
  spin_sweep_updater_if.master    eng,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    converged_o,
  output logic [FLIP_CNT_BIT-1:0] flip_cnt_o,
  output logic [1:0]              dbg_state_o
);

  localparam logic [IDX_BIT-1:0]      LAST_IDX = IDX_BIT'(DATASPIN - 1);
  localparam logic [FLIP_CNT_BIT-1:0] FLIP_SAT = FLIP_CNT_BIT'(FLIP_CNT_SAT);

  state_e                  state_q, state_d;
  logic [DATASPIN-1:0]     spin_q, spin_d;
  logic [IDX_BIT-1:0]      idx_q, idx_d;
  logic [SWEEP_BIT-1:0]    sweep_q, sweep_d;
  logic [SWEEP_BIT-1:0]    num_sweeps_q, num_sweeps_d;
  logic [FLIP_CNT_BIT-1:0] flip_cnt_q, flip_cnt_d;
  logic                    converged_q, converged_d;
  logic                    flag_q, flag_d;

  logic flip;
  logic sweep_flipped;

  spin_flip_decide #(
    .W (LOCAL_ENERGY_BIT)
  ) u_flip_decide (
    .energy_i (eng.energy_i),
    .flip_o   (flip)
  );

  always_comb begin
    state_d       = state_q;
    spin_d        = spin_q;
    idx_d         = idx_q;
    sweep_d       = sweep_q;
    num_sweeps_d  = num_sweeps_q;
    flip_cnt_d    = flip_cnt_q;
    converged_d   = converged_q;
    flag_d        = flag_q;
    sweep_flipped = flag_q | flip;

    unique case (state_q)
      IDLE: begin
        // Load and start may coincide; the run then begins on the freshly loaded vector.
        if (spin_load_valid_i) begin
          spin_d = spin_load_i;
        end
        if (start_i) begin
          num_sweeps_d = num_sweeps_i;
          flip_cnt_d   = '0;
          converged_d  = 1'b0;
          flag_d       = 1'b0;
          idx_d        = '0;
          sweep_d      = '0;
          state_d      = (num_sweeps_i == '0) ? FINISH : RUN;
        end
      end

      RUN: begin
        if (eng.energy_valid_i) begin
          if (flip) begin
            spin_d[idx_q] = ~spin_q[idx_q];
            flag_d        = 1'b1;
            if (flip_cnt_q != FLIP_SAT) begin
              flip_cnt_d = flip_cnt_q + 1'b1;
            end
          end
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + 1'b1;
          end else begin
            sweep_d = sweep_q + 1'b1;
            idx_d   = '0;
            flag_d  = 1'b0;
            if (!sweep_flipped) begin
              converged_d = 1'b1;
              state_d     = FINISH;
            end else if (sweep_d == num_sweeps_q) begin
              state_d = FINISH;
            end
          end
        end
      end

      FINISH: begin
        idx_d   = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      spin_q       <= '0;
      idx_q        <= '0;
      sweep_q      <= '0;
      num_sweeps_q <= '0;
      flip_cnt_q   <= '0;
      converged_q  <= 1'b0;
      flag_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      spin_q       <= spin_d;
      idx_q        <= idx_d;
      sweep_q      <= sweep_d;
      num_sweeps_q <= num_sweeps_d;
      flip_cnt_q   <= flip_cnt_d;
      converged_q  <= converged_d;
      flag_q       <= flag_d;
    end
  end

  assign eng.spin_o         = spin_q;
  assign eng.spin_idx_o     = idx_q;
  assign eng.current_spin_o = spin_q[idx_q];
  assign eng.energy_ready_o = (state_q == RUN);

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == FINISH);
  assign converged_o = converged_q;
  assign flip_cnt_o  = flip_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spin_sweep_updater.sv
// Directed bench for spin_sweep_updater on 4 spins; a second instance with a 3-bit flip counter shares stimulus.
module tb_spin_sweep_updater;

  localparam int NS  = 4;
  localparam int LEB = 16;
  localparam int SB  = 8;

  logic              clk;
  logic              rst_n;
  logic              spin_load_valid;
  logic [NS-1:0]     spin_load;
  logic              start;
  logic [SB-1:0]     num_sweeps;
  logic              energy_valid;
  logic signed [LEB-1:0] energy;

  logic              busy_a, done_a, conv_a;
  logic [15:0]       flip_cnt_a;
  logic [1:0]        state_a;
  logic              busy_b, done_b, conv_b;
  logic [2:0]        flip_cnt_b;
  logic [1:0]        state_b;

  int n_checks;
  int n_fail;

  spin_sweep_updater_if #(.DATASPIN(NS), .LOCAL_ENERGY_BIT(LEB)) bus_a ();
  spin_sweep_updater_if #(.DATASPIN(NS), .LOCAL_ENERGY_BIT(LEB)) bus_b ();

  assign bus_a.energy_valid_i = energy_valid;
  assign bus_a.energy_i       = energy;
  assign bus_b.energy_valid_i = energy_valid;
  assign bus_b.energy_i       = energy;

  spin_sweep_updater #(
    .DATASPIN(NS), .LOCAL_ENERGY_BIT(LEB), .SWEEP_BIT(SB), .FLIP_CNT_BIT(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .spin_load_valid_i(spin_load_valid), .spin_load_i(spin_load),
    .start_i(start), .num_sweeps_i(num_sweeps), .eng(bus_a), .busy_o(busy_a), .done_o(done_a),
    .converged_o(conv_a), .flip_cnt_o(flip_cnt_a), .dbg_state_o(state_a)
  );

  spin_sweep_updater #(
    .DATASPIN(NS), .LOCAL_ENERGY_BIT(LEB), .SWEEP_BIT(SB), .FLIP_CNT_BIT(3)
  ) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .spin_load_valid_i(spin_load_valid), .spin_load_i(spin_load),
    .start_i(start), .num_sweeps_i(num_sweeps), .eng(bus_b), .busy_o(busy_b), .done_o(done_b),
    .converged_o(conv_b), .flip_cnt_o(flip_cnt_b), .dbg_state_o(state_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic start_run(input logic [NS-1:0] vec, input logic [SB-1:0] n);
    spin_load_valid = 1'b1;
    spin_load       = vec;
    start           = 1'b1;
    num_sweeps      = n;
    step();
    spin_load_valid = 1'b0;
    start           = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; spin_load_valid = 1'b0; spin_load = '0; start = 1'b0;
    num_sweeps = '0; energy_valid = 1'b0; energy = '0;
    step(); step();
    n_checks++; if (bus_a.spin_o !== 4'b0000) begin n_fail++; $display("FAIL reset_spin: got %b expected 0000", bus_a.spin_o); end
    n_checks++; if (bus_a.spin_idx_o !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", bus_a.spin_idx_o); end
    n_checks++; if ({bus_a.energy_ready_o, busy_a, done_a, conv_a} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {bus_a.energy_ready_o, busy_a, done_a, conv_a}); end
    n_checks++; if (flip_cnt_a !== 16'd0) begin n_fail++; $display("FAIL reset_flip_cnt: got %0d expected 0", flip_cnt_a); end
    n_checks++; if (state_a !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_a); end
    rst_n = 1'b1;
    step();
  endtask

  // Load 0000, one sweep, energies 5,0,-3,1 -> spins 0 and 3 flip.
  task automatic test_single_sweep();
    logic signed [LEB-1:0] e_tab [NS];
    logic [NS-1:0]         exp_spin [NS];
    e_tab    = '{16'sd5, 16'sd0, -16'sd3, 16'sd1};
    exp_spin = '{4'b0000, 4'b0001, 4'b0001, 4'b0001};
    start_run(4'b0000, 8'd1);
    n_checks++; if ({busy_a, bus_a.energy_ready_o} !== 2'b11) begin n_fail++; $display("FAIL sweep1_busy_ready: got %b expected 11", {busy_a, bus_a.energy_ready_o}); end
    for (int i = 0; i < NS; i++) begin
      n_checks++; if (bus_a.spin_idx_o !== 2'(i)) begin n_fail++; $display("FAIL sweep1_idx%0d: got %0d expected %0d", i, bus_a.spin_idx_o, i); end
      n_checks++; if (bus_a.spin_o !== exp_spin[i]) begin n_fail++; $display("FAIL sweep1_spin_before%0d: got %b expected %b", i, bus_a.spin_o, exp_spin[i]); end
      energy_valid = 1'b1;
      energy       = e_tab[i];
      step();
    end
    energy_valid = 1'b0;
    n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL sweep1_done: got %b expected 1", done_a); end
    n_checks++; if (bus_a.spin_o !== 4'b1001) begin n_fail++; $display("FAIL sweep1_spin: got %b expected 1001", bus_a.spin_o); end
    n_checks++; if (flip_cnt_a !== 16'd2) begin n_fail++; $display("FAIL sweep1_flip_cnt: got %0d expected 2", flip_cnt_a); end
    n_checks++; if (conv_a !== 1'b0) begin n_fail++; $display("FAIL sweep1_converged: got %b expected 0", conv_a); end
    n_checks++; if (bus_a.energy_ready_o !== 1'b0) begin n_fail++; $display("FAIL sweep1_ready_finish: got %b expected 0", bus_a.energy_ready_o); end
    step();
    n_checks++; if ({done_a, busy_a} !== 2'b00) begin n_fail++; $display("FAIL sweep1_done_pulse: got %b expected 00", {done_a, busy_a}); end
    n_checks++; if (bus_a.spin_idx_o !== 2'd0) begin n_fail++; $display("FAIL sweep1_idx_after: got %0d expected 0", bus_a.spin_idx_o); end
  endtask

  // Load 1111, three sweeps, all energies negative -> converge after the first sweep.
  task automatic test_converge();
    start_run(4'b1111, 8'd3);
    n_checks++; if (bus_a.current_spin_o !== 1'b1) begin n_fail++; $display("FAIL conv_current_spin: got %b expected 1", bus_a.current_spin_o); end
    energy_valid = 1'b1;
    energy       = -16'sd1;
    for (int i = 0; i < NS; i++) step();
    energy_valid = 1'b0;
    n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL conv_done: got %b expected 1", done_a); end
    n_checks++; if (conv_a !== 1'b1) begin n_fail++; $display("FAIL conv_flag: got %b expected 1", conv_a); end
    n_checks++; if (flip_cnt_a !== 16'd0) begin n_fail++; $display("FAIL conv_flip_cnt: got %0d expected 0", flip_cnt_a); end
    n_checks++; if (bus_a.spin_o !== 4'b1111) begin n_fail++; $display("FAIL conv_spin: got %b expected 1111", bus_a.spin_o); end
    step();
    n_checks++; if ({done_a, busy_a, conv_a} !== 3'b001) begin n_fail++; $display("FAIL conv_held: got %b expected 001", {done_a, busy_a, conv_a}); end
  endtask

  // Zero sweeps: straight to FINISH, never ready.
  task automatic test_zero_sweeps();
    start_run(4'b0101, 8'd0);
    n_checks++; if ({busy_a, done_a, bus_a.energy_ready_o} !== 3'b110) begin n_fail++; $display("FAIL zero_finish: got %b expected 110", {busy_a, done_a, bus_a.energy_ready_o}); end
    n_checks++; if (conv_a !== 1'b0) begin n_fail++; $display("FAIL zero_conv_cleared: got %b expected 0", conv_a); end
    step();
    n_checks++; if ({busy_a, done_a, bus_a.energy_ready_o} !== 3'b000) begin n_fail++; $display("FAIL zero_idle: got %b expected 000", {busy_a, done_a, bus_a.energy_ready_o}); end
    n_checks++; if (bus_a.spin_o !== 4'b0101) begin n_fail++; $display("FAIL zero_spin: got %b expected 0101", bus_a.spin_o); end
  endtask

  // Two always-flip sweeps with random valid gaps; the 3-bit counter saturates at 7.
  task automatic test_random_gaps();
    int  hs;
    bit  seen_done;
    bit  mid_checked;
    hs = 0; seen_done = 1'b0; mid_checked = 1'b0;
    start_run(4'b0110, 8'd2);
    energy = 16'sh7FFF;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (done_a) begin
        seen_done = 1'b1;
        break;
      end
      if (hs == NS && !mid_checked) begin
        mid_checked = 1'b1;
        n_checks++; if (bus_a.spin_o !== 4'b1001) begin n_fail++; $display("FAIL gaps_mid_spin: got %b expected 1001", bus_a.spin_o); end
      end
      energy_valid = 1'($urandom_range(0, 1));
      if (energy_valid && bus_a.energy_ready_o) hs++;
      step();
    end
    energy_valid = 1'b0;
    n_checks++; if (!seen_done) begin n_fail++; $display("FAIL gaps_timeout: got no done expected done within 200 cycles"); end
    n_checks++; if (hs !== 2 * NS) begin n_fail++; $display("FAIL gaps_handshakes: got %0d expected %0d", hs, 2 * NS); end
    n_checks++; if (bus_a.spin_o !== 4'b0110) begin n_fail++; $display("FAIL gaps_spin: got %b expected 0110", bus_a.spin_o); end
    n_checks++; if (flip_cnt_a !== 16'd8) begin n_fail++; $display("FAIL gaps_flip_cnt: got %0d expected 8", flip_cnt_a); end
    n_checks++; if (flip_cnt_b !== 3'd7) begin n_fail++; $display("FAIL sat_flip_cnt: got %0d expected 7", flip_cnt_b); end
    n_checks++; if ({done_b, conv_a} !== 2'b10) begin n_fail++; $display("FAIL gaps_done_conv: got %b expected 10", {done_b, conv_a}); end
    step();
  endtask

  // start/load during RUN are ignored; reset mid-sweep aborts without done.
  task automatic test_reset_midrun();
    start_run(4'b0000, 8'd2);
    energy_valid    = 1'b1;
    energy          = 16'sd5;
    start           = 1'b1;
    spin_load_valid = 1'b1;
    spin_load       = 4'b1111;
    num_sweeps      = 8'd0;
    step();
    start           = 1'b0;
    spin_load_valid = 1'b0;
    n_checks++; if (bus_a.spin_o !== 4'b0001) begin n_fail++; $display("FAIL run_ignore_spin: got %b expected 0001", bus_a.spin_o); end
    n_checks++; if ({busy_a, bus_a.spin_idx_o} !== 3'b101) begin n_fail++; $display("FAIL run_ignore_busy_idx: got %b expected 101", {busy_a, bus_a.spin_idx_o}); end
    step();
    n_checks++; if (bus_a.spin_o !== 4'b0011) begin n_fail++; $display("FAIL run_second_spin: got %b expected 0011", bus_a.spin_o); end
    rst_n        = 1'b0;
    energy_valid = 1'b0;
    step();
    n_checks++; if ({bus_a.spin_o, bus_a.spin_idx_o} !== 6'd0) begin n_fail++; $display("FAIL midrst_spin_idx: got %b expected 000000", {bus_a.spin_o, bus_a.spin_idx_o}); end
    n_checks++; if ({bus_a.energy_ready_o, busy_a, done_a, conv_a} !== 4'b0000) begin n_fail++; $display("FAIL midrst_flags: got %b expected 0000", {bus_a.energy_ready_o, busy_a, done_a, conv_a}); end
    n_checks++; if ({flip_cnt_a, flip_cnt_b} !== 19'd0) begin n_fail++; $display("FAIL midrst_flip_cnt: got %0d/%0d expected 0/0", flip_cnt_a, flip_cnt_b); end
    rst_n = 1'b1;
    step();
    n_checks++; if ({done_a, busy_a} !== 2'b00) begin n_fail++; $display("FAIL midrst_no_done: got %b expected 00", {done_a, busy_a}); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_sweep();
    test_converge();
    test_zero_sweeps();
    test_random_gaps();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spin_sweep_updater.md
# spin_sweep_updater

Sequential spin-update controller that writes the spin state consumed by the per-spin partial energy calculator. It walks spin indices in order, presents the live spin vector, index and current spin value to the energy path, accepts the returned local energy over a valid/ready handshake, and flips the spin when that lowers energy. The block runs a programmable number of Gauss-Seidel sweeps, stops early on convergence, and reports done, flip count and convergence status.

## Interface
- DATASPIN, 256, number of spins
- LOCAL_ENERGY_BIT, 16, width of the signed local energy input
- SWEEP_BIT, 8, width of the sweep-count input
- FLIP_CNT_BIT, 16, width of the saturating flip counter
- IDX_BIT, $clog2(DATASPIN), width of the spin index
- clk_i  in  1  clock; one clock domain
- rst_ni  in  1  reset, synchronous, active-low
- spin_load_valid_i  in  1  load spin_load_i into the spin register (IDLE only)
- spin_load_i  in  DATASPIN  initial spin vector
- start_i  in  1  start a run (IDLE only)
- num_sweeps_i  in  SWEEP_BIT  sweeps to run; latched at start
- spin_o  out  DATASPIN  registered spin vector; drives the energy calculator's spin_i
- spin_idx_o  out  IDX_BIT  index of the spin under evaluation
- current_spin_o  out  1  spin_o[spin_idx_o]
- energy_valid_i  in  1  local energy for spin_idx_o is valid
- energy_i  in  LOCAL_ENERGY_BIT  signed local energy of spin_idx_o at its current value
- energy_ready_o  out  1  block accepts energy_i this cycle
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle pulse at run end
- converged_o  out  1  last run ended on a sweep with zero flips; held until next start
- flip_cnt_o  out  FLIP_CNT_BIT  flips in the current/last run, saturating

## Operation
- States: IDLE, RUN, FINISH.
- IDLE: spin_load_valid_i writes spin_o. start_i latches num_sweeps_i, clears flip_cnt_o, converged_o and the per-sweep flip flag, sets idx=0 and sweep=0; goes to RUN, or to FINISH if num_sweeps_i==0.
- Load and start in the same IDLE cycle: both take effect; the run uses the loaded vector.
- RUN: energy_ready_o=1. On energy_valid_i && energy_ready_o:
  - flip iff energy_i > 0 (signed, strict); energy_i==0 or negative keeps the spin;
  - on flip: spin_o[idx] inverted, flip_cnt_o += 1 (saturates at all-ones), per-sweep flag set;
  - if idx != DATASPIN-1: idx += 1;
  - else end of sweep: sweep += 1; if the flag is clear, set converged_o and go to FINISH; if sweep == latched count, go to FINISH; otherwise idx=0, clear the flag, stay in RUN.
- FINISH: done_o=1 for exactly one cycle, idx returns to 0, next state IDLE.
- spin_load_valid_i and start_i outside IDLE are ignored.
- busy_o=1 in RUN and FINISH.

## Timing
- Reset (rst_ni low at clk_i edge): state IDLE, spin_o=0, spin_idx_o=0, energy_ready_o=0, busy_o=0, done_o=0, converged_o=0, flip_cnt_o=0.
- Reset mid-run aborts the run immediately with no done_o pulse.
- energy_ready_o, busy_o and current_spin_o decode from registered state only. There is no combinational path from energy_valid_i.
- A spin update is visible on spin_o one cycle after the accepting edge, together with the new spin_idx_o. The next evaluation therefore sees the updated vector (Gauss-Seidel ordering).
- With energy_valid_i held high by a combinational energy source, throughput is 1 spin/cycle. A full run is num_sweeps*DATASPIN RUN cycles plus 1 FINISH cycle.
- start→busy_o: 1 cycle. Final handshake→done_o: 1 cycle.

## Structure
- Shared package spin_update_pkg holds the state enum typedef (IDLE/RUN/FINISH) and the localparam for the flip-counter saturation value.
- One sub-module, spin_flip_decide: combinational signed compare energy_i > 0 that outputs the flip bit.
- Counters and the spin register stay in the top module.

## Test plan
- DATASPIN=4: reset, then load 4'b0000; start with num_sweeps_i=1; energies 5,0,-3,1 with valid held high → spin_o=4'b1001, flip_cnt_o=2, done_o high exactly 1 cycle after the 4th handshake, converged_o=0.
- Load 4'b1111, num_sweeps_i=3, all energies -1 → done_o after sweep 1 (5 cycles after start), converged_o=1, flip_cnt_o=0, spin_o unchanged.
- num_sweeps_i=0 → done_o 1 cycle after start, busy_o for 1 cycle, no energy_ready_o.
- Random valid gaps (50%) with energy_i=0x7FFF every handshake, num_sweeps_i=2 → each spin toggles twice, spin_o back to the loaded value, flip_cnt_o=8.
- Assert rst_ni low in the middle of a sweep → all outputs at reset values next cycle, no done_o; start_i and spin_load_valid_i pulsed during RUN have no effect.
- FLIP_CNT_BIT=3 with 2 sweeps of always-flip on 4 spins → flip_cnt_o saturates at 7.
